xbar_ingress_queue: RTL and testbench
=====================================

// Module: xbar_ingress_queue
// PURPOSE
//  Per-input ingress buffer that sits directly upstream of one crossbar_switch input port.
//  Accepts {dest, data} words from the source on a valid/ready handshake.
//  Stores them in order and presents the head word to the crossbar as req/dest/data_in.
//  Retires the head when the crossbar grants it, and flags a head word that is starved of grants.
// PARAMETERS
//  DATA_W        32   payload width; matches crossbar data_in
//  M             4    number of crossbar outputs; DEST_W = $clog2(M) (localparam)
//  DEPTH         4    queue entries; power of two, >= 2
//  STARVE_LIMIT  15   consecutive ungranted cycles before starve asserts
// PORTS
//  clk        in   1             clock; all state updates on posedge
//  rst        in   1             synchronous reset, active-high
//  in_valid   in   1             source has a word
//  in_ready   out  1             queue can accept a word
//  in_dest    in   DEST_W        destination output index
//  in_data    in   DATA_W        payload
//  xb_req     out  1             to crossbar req[i]; head word valid
//  xb_dest    out  DEST_W        to crossbar dest[i]; head destination
//  xb_data    out  DATA_W        to crossbar data_in[i]; head payload
//  xb_grant   in   1             from crossbar grant[i]
//  occupancy  out  $clog2(DEPTH)+1  entries held, 0..DEPTH
//  starve     out  1             head has waited STARVE_LIMIT cycles without a grant
// BEHAVIOUR
//  Reset: rd/wr pointers=0, occupancy=0, wait_cnt=0, so xb_req=0, in_ready=1, starve=0.
//   Storage array is not reset.
//  Reset mid-operation flushes all entries; words held at that edge are lost and no grant is honoured.
//  Push: in_valid & in_ready at posedge. Entry written at wr_ptr; wr_ptr wraps modulo DEPTH.
//  in_ready = (occupancy != DEPTH). No full-queue bypass: a pop in the same cycle does not raise in_ready.
//  Pop: xb_req & xb_grant at posedge retires the head; rd_ptr wraps modulo DEPTH.
//   xb_grant while xb_req=0 is ignored.
//  Push and pop in the same cycle: occupancy unchanged, both pointers advance.
//  Latency: a word pushed into an empty queue raises xb_req on the next cycle. No write-to-head bypass.
//  xb_req = (occupancy != 0). xb_dest/xb_data = head entry when xb_req=1, else all-zero.
//   These are combinational from registered storage and pointers.
//  Head word is held stable (dest and data) until granted. The source cannot alter a queued word.
//  Ordering: strict FIFO. Head-of-line blocking is intended; no reordering by destination.
//  Starvation counter wait_cnt (width $clog2(STARVE_LIMIT+1)):
//   - cleared when xb_req=0 or on a pop;
//   - else incremented each cycle, saturating at STARVE_LIMIT.
//   starve = (wait_cnt == STARVE_LIMIT), registered. It stays high until the grant.
//   After the pop the counter restarts from 0 for the next head.
//  occupancy is registered and reflects the state after the current edge.
// STRUCTURE
//  xbar_pkg: DATA_W, M, DEST_W constants and typedef xb_entry_t {dest, data}.
//   Shared with crossbar_switch.
//  Sub-module sync_fifo (parameterised width/depth; push/pop/full/empty/count/head).
//   Instantiated with width DEST_W+DATA_W.
//  Top level adds the handshake mapping, output gating and starvation counter.
// TESTING
//  1. Reset, push {dest=2, data=A1A1A1A1}, grant tied 1:
//     xb_req rises 1 cycle after push, with xb_dest=2 and xb_data=A1A1A1A1.
//     Popped on the next edge; occupancy returns to 0.
//  2. Grant 0, push 5 words:
//     in_ready drops after the 4th; occupancy=4; 5th held by the source.
//     Grants then drain the words in push order.
//  3. Full queue, push+grant in the same cycle:
//     no push accepted; occupancy 4->3; in_ready=1 on the next cycle.
//  4. Head ungranted 15 cycles:
//     starve=1 at cycle 15 and stays high.
//     Grant -> starve=0 the next cycle; wait_cnt restarts for the new head.
//  5. Occupancy=3, then rst=1 for 1 cycle with grant=1:
//     xb_req=0, occupancy=0, in_ready=1; no data emitted after reset.
//  6. Continuous push+grant over 2*DEPTH+1 words:
//     pointer wrap is lossless and in order; occupancy constant at 1.

Source files
------------

// File: rtl/xbar_pkg.sv
// Crossbar-wide constants and the {dest, data} entry type shared by the
// crossbar and its per-input ingress queues.
package xbar_pkg;
  localparam int DATA_W = 32;
  localparam int M      = 4;
  localparam int DEST_W = $clog2(M);

  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } xb_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered count and a combinational head read.
// Push is dropped when full and pop is dropped when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/xbar_ingress_queue.sv
// Ingress buffer for one crossbar input: FIFO of {dest, data}, head presented
// as a request, retired on grant, with a saturating head-starvation flag.
module xbar_ingress_queue import xbar_pkg::*; #(
  parameter int DATA_W       = xbar_pkg::DATA_W,
  parameter int M            = xbar_pkg::M,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [$clog2(M)-1:0]      in_dest_i,
  input  logic [DATA_W-1:0]         in_data_i,
  output logic                      xb_req_o,
  output logic [$clog2(M)-1:0]      xb_dest_o,
  output logic [DATA_W-1:0]         xb_data_o,
  input  logic                      xb_grant_i,
  output logic [$clog2(DEPTH):0]    occupancy_o,
  output logic                      starve_o
);
  localparam int DEST_W = $clog2(M);
  localparam int ENT_W  = DEST_W + DATA_W;
  localparam int SW     = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] WAIT_MAX = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] WAIT_ONE = SW'(1);

  logic [ENT_W-1:0] head;
  logic             full, empty, pop;
  logic [SW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             starve_q;

  sync_fifo #(.WIDTH(ENT_W), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (in_valid_i),
    .pop_i   (pop),
    .wdata_i ({in_dest_i, in_data_i}),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy_o),
    .head_o  (head)
  );

  // No full-queue bypass: readiness depends only on registered occupancy.
  assign in_ready_o = ~full;
  assign xb_req_o   = ~empty;
  assign pop        = xb_req_o & xb_grant_i;
  assign xb_dest_o  = xb_req_o ? head[ENT_W-1 -: DEST_W] : '0;
  assign xb_data_o  = xb_req_o ? head[DATA_W-1:0]       : '0;
  assign starve_o   = starve_q;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!xb_req_o || pop)          wait_cnt_d = '0;
    else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_ONE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
      starve_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      starve_q   <= (wait_cnt_d == WAIT_MAX);
    end
  end
endmodule

// File: tb/tb_xbar_ingress_queue.sv
// Directed bench for xbar_ingress_queue: accepted words go into an expected
// queue, and a monitor checks every granted head word against it in order.
module tb_xbar_ingress_queue;
  import xbar_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DEST_W-1:0] in_dest;
  logic [DATA_W-1:0] in_data;
  logic              xb_req;
  logic [DEST_W-1:0] xb_dest;
  logic [DATA_W-1:0] xb_data;
  logic              xb_grant;
  logic [2:0]        occupancy;
  logic              starve;

  int checks = 0;
  int errors = 0;
  int npop   = 0;
  xb_entry_t exp_q[$];

  xbar_ingress_queue dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_dest_i   (in_dest),
    .in_data_i   (in_data),
    .xb_req_o    (xb_req),
    .xb_dest_o   (xb_dest),
    .xb_data_o   (xb_data),
    .xb_grant_i  (xb_grant),
    .occupancy_o (occupancy),
    .starve_o    (starve)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: mid-cycle, inputs and outputs are settled for the coming edge.
  always @(negedge clk) begin
    if (!rst && xb_req && xb_grant) begin
      xb_entry_t got;
      got.dest = xb_dest;
      got.data = xb_data;
      npop++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h, expected no grantable word", got);
      end else begin
        xb_entry_t e;
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL pop_order: got %0h, expected %0h at %0t", got, e, $time);
        end
      end
    end
    if (!rst && in_valid && in_ready) exp_q.push_back({in_dest, in_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0; xb_grant = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_occ",    occupancy, 0);
    chk("rst_req",    xb_req,    0);
    chk("rst_ready",  in_ready,  1);
    chk("rst_starve", starve,    0);
    chk("rst_gated",  {xb_dest, xb_data}, 0);

    // 1: single word, grant tied high
    xb_grant = 1'b1;
    in_valid = 1'b1; in_dest = 2'd2; in_data = 32'hA1A1_A1A1;
    step();
    in_valid = 1'b0;
    chk("t1_req",  xb_req,  1);
    chk("t1_dest", xb_dest, 2);
    chk("t1_data", xb_data, 32'hA1A1_A1A1);
    chk("t1_occ",  occupancy, 1);
    step();
    chk("t1_occ_after", occupancy, 0);
    chk("t1_req_after", xb_req, 0);

    // 2: fill with grant low, fifth word held by the source
    xb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dest = 2'(i); in_data = 32'h1000_0000 + 32'(i);
      step();
    end
    chk("t2_occ_full",  occupancy, 4);
    chk("t2_ready_low", in_ready,  0);
    in_dest = 2'd3; in_data = 32'h5555_5555;
    step();
    chk("t2_occ_hold",  occupancy, 4);
    chk("t2_head_dest", xb_dest, 0);
    chk("t2_head_data", xb_data, 32'h1000_0000);

    // 3: full queue, push and grant together: no push accepted this edge
    xb_grant = 1'b1;
    step();
    chk("t3_occ_3",   occupancy, 3);
    chk("t3_ready",   in_ready,  1);
    step();
    chk("t3_occ_pp",  occupancy, 3);
    in_valid = 1'b0;
    step(3);
    chk("t3_drained", occupancy, 0);

    // 4: starvation of an ungranted head
    xb_grant = 1'b0;
    in_valid = 1'b1; in_dest = 2'd1; in_data = 32'hBEEF_0001;
    step();
    in_dest = 2'd0; in_data = 32'hBEEF_0002;
    step();
    in_valid = 1'b0;
    chk("t4_starve_early", starve, 0);
    step(13);
    chk("t4_starve_14", starve, 0);
    step();
    chk("t4_starve_15", starve, 1);
    step(3);
    chk("t4_starve_hold", starve, 1);
    xb_grant = 1'b1;
    step();
    xb_grant = 1'b0;
    chk("t4_starve_clr", starve, 0);
    chk("t4_occ", occupancy, 1);
    step(14);
    chk("t4_new_head_14", starve, 0);
    step();
    chk("t4_new_head_15", starve, 1);
    xb_grant = 1'b1;
    step();
    xb_grant = 1'b0;
    chk("t4_final_starve", starve, 0);
    chk("t4_final_occ", occupancy, 0);

    // 5: reset with three words queued and grant high
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dest = 2'(i); in_data = 32'hDEAD_0000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    chk("t5_occ_3", occupancy, 3);
    xb_grant = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    chk("t5_req",    xb_req,    0);
    chk("t5_occ",    occupancy, 0);
    chk("t5_ready",  in_ready,  1);
    chk("t5_starve", starve,    0);
    step(3);
    chk("t5_still_empty", occupancy, 0);

    // 6: continuous push+grant across pointer wrap
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_dest = 2'(i % 4); in_data = 32'hC0DE_0000 + 32'(i);
      step();
      chk("t6_occ", occupancy, 1);
    end
    in_valid = 1'b0;
    step();
    xb_grant = 1'b0;
    chk("t6_occ_end", occupancy, 0);
    step(2);

    chk("sb_empty", exp_q.size(), 0);
    chk("sb_pops",  npop, 17);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
